// File: rtl/mult_seq16_pkg.sv
// Shared constants for the sequential 16x16 multiplier and its control unit.
package mult_seq16_pkg;

    // Operand width; the product is twice as wide
    localparam int LARGURA   = 16;

    // Iteration counter width; 2**LARG_CONT must exceed LARGURA
    localparam int LARG_CONT = 5;

    // Shift-add iterations per operation (one per multiplier bit)
    localparam int ITERACOES = LARGURA;

    // Edges from the iniciar edge until pronto is visible:
    // one per iteration plus the FIM edge
    localparam int LATENCIA  = ITERACOES + 1;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        CALCULA = 2'b01,
        FIM     = 2'b10
    } estado_t;

endpackage

// File: rtl/mult_seq16.sv
// Sequential shift-add multiplier, unsigned or two's complement, fixed latency.
// Signed operands are reduced to magnitudes up front and the sign is applied
// once at the end, so the iteration loop itself is always unsigned.
module mult_seq16
    import mult_seq16_pkg::*;
#(
    parameter int LARGURA   = mult_seq16_pkg::LARGURA,
    parameter int LARG_CONT = mult_seq16_pkg::LARG_CONT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               comSinal,
    input  logic [LARGURA-1:0] entradaA,
    input  logic [LARGURA-1:0] entradaB,
    output logic [LARGURA-1:0] saidaHi,
    output logic [LARGURA-1:0] saidaLo,
    output logic               pronto,
    output logic               ocupado
);

    localparam logic [LARG_CONT-1:0] ULTIMA = LARG_CONT'(LARGURA - 1);

    estado_t                  estado;
    estado_t                  proximo;
    logic [2*LARGURA-1:0]     acc;
    logic [LARGURA-1:0]       mcand;
    logic [LARGURA-1:0]       mplier;
    logic [LARG_CONT-1:0]     contador;
    logic                     sinal_neg;

    logic [LARGURA-1:0]       a_mag;
    logic [LARGURA-1:0]       b_mag;
    logic [LARGURA:0]         soma;
    logic [2*LARGURA-1:0]     produto;

    // Operand magnitudes, the 17-bit partial sum and the signed final product
    always_comb begin
        a_mag   = entradaA;
        b_mag   = entradaB;
        if (comSinal && entradaA[LARGURA-1]) a_mag = -entradaA;
        if (comSinal && entradaB[LARGURA-1]) b_mag = -entradaB;
        soma    = {1'b0, acc[2*LARGURA-1:LARGURA]}
                + (mplier[0] ? {1'b0, mcand} : '0);
        produto = sinal_neg ? -acc : acc;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state logic; ocupado covers CALCULA and FIM
    always_comb begin
        proximo = estado;
        ocupado = 1'b0;
        case (estado)
            OCIOSO: begin
                if (iniciar) proximo = CALCULA;
            end
            CALCULA: begin
                ocupado = 1'b1;
                if (contador == ULTIMA) proximo = FIM;
            end
            FIM: begin
                ocupado = 1'b1;
                proximo = OCIOSO;
            end
            default: begin
                proximo = OCIOSO;
            end
        endcase
    end

    // Datapath: operand capture, shift-add iterations and result write-back.
    // The accumulator's low half fills with product bits as the multiplier
    // shifts out, so after the last iteration acc holds the full magnitude.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            contador  <= '0;
            sinal_neg <= 1'b0;
            saidaHi   <= '0;
            saidaLo   <= '0;
            pronto    <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        mcand     <= a_mag;
                        mplier    <= b_mag;
                        sinal_neg <= comSinal
                                   & (entradaA[LARGURA-1] ^ entradaB[LARGURA-1]);
                        acc       <= '0;
                        contador  <= '0;
                    end
                end
                CALCULA: begin
                    acc      <= {soma, acc[LARGURA-1:1]};
                    mplier   <= {1'b0, mplier[LARGURA-1:1]};
                    contador <= contador + LARG_CONT'(1);
                end
                FIM: begin
                    saidaHi <= produto[2*LARGURA-1:LARGURA];
                    saidaLo <= produto[LARGURA-1:0];
                    pronto  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq16.sv
// Directed self-checking bench for mult_seq16.
module tb_mult_seq16;

    logic        clock;
    logic        reset;
    logic        iniciar;
    logic        comSinal;
    logic [15:0] entradaA;
    logic [15:0] entradaB;
    logic [15:0] saidaHi;
    logic [15:0] saidaLo;
    logic        pronto;
    logic        ocupado;

    int checks;
    int errors;

    mult_seq16 dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .comSinal (comSinal),
        .entradaA (entradaA),
        .entradaB (entradaB),
        .saidaHi  (saidaHi),
        .saidaLo  (saidaLo),
        .pronto   (pronto),
        .ocupado  (ocupado)
    );

    // 100 MHz clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One comparison: counts it, and on a mismatch reports and counts the failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
            $error("[TB] %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Presents operands with a one-cycle iniciar pulse; returns at the
    // negedge following the sampling edge (edge 0)
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic s);
        @(negedge clock);
        entradaA = a;
        entradaB = b;
        comSinal = s;
        iniciar  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        iniciar  = 1'b0;
    endtask

    // Waits (bounded) for pronto; reports the edge count, busy cycles and product
    task automatic waitDone(output int lat, output int busy, output logic [31:0] prod);
        lat  = -1;
        busy = ocupado ? 1 : 0;
        prod = 32'hDEAD_BEEF;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (pronto) begin
                lat  = k;
                prod = {saidaHi, saidaLo};
                break;
            end
            if (ocupado) busy++;
        end
    endtask

    // Full operation: checks latency, busy span, product and pronto width
    task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [31:0] expected);
        int          lat;
        int          busy;
        logic [31:0] prod;
        applyStimulus(a, b, s);
        waitDone(lat, busy, prod);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd17);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd17);
        checkOutput({tag, "_product"}, prod, expected);
        @(posedge clock);
        @(negedge clock);
        checkOutput({tag, "_pronto_pulse"}, {31'd0, pronto}, 32'd0);
    endtask

    initial begin
        int          pronto_hits;
        int          lo_changes;
        int          pronto_at;
        logic [31:0] held;

        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        iniciar  = 1'b0;
        comSinal = 1'b0;
        entradaA = 16'h0000;
        entradaB = 16'h0000;

        // Reset state
        #12;
        checkOutput("reset_outputs", {saidaHi, saidaLo}, 32'h0000_0000);
        checkOutput("reset_flags", {30'd0, pronto, ocupado}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Basic unsigned, with latency/busy checks
        runOp("u_3x5", 16'd3, 16'd5, 1'b0, 32'h0000_000F);

        // Result held over 20 idle cycles with changing operands
        pronto_hits = 0;
        lo_changes  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            entradaA = 16'(i * 16'h1111);
            entradaB = 16'(16'hFFFF - i);
            comSinal = i[0];
            @(posedge clock);
            #1;
            if (pronto) pronto_hits++;
            if ({saidaHi, saidaLo} !== 32'h0000_000F) lo_changes++;
        end
        checkOutput("idle_pronto", 32'(pronto_hits), 32'd0);
        checkOutput("idle_hold", 32'(lo_changes), 32'd0);

        // Arithmetic boundaries
        runOp("u_max", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        runOp("u_8000x1", 16'h8000, 16'h0001, 1'b0, 32'h0000_8000);
        runOp("s_m1x7", 16'hFFFF, 16'h0007, 1'b1, 32'hFFFF_FFF9);
        runOp("s_minxmin", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        runOp("s_minx1", 16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000);
        runOp("s_5xm3", 16'h0005, 16'hFFFD, 1'b1, 32'hFFFF_FFF1);
        runOp("s_zero_neg", 16'h0000, 16'h8000, 1'b1, 32'h0000_0000);

        // iniciar re-pulsed at edges 5 and 17 of an operation is ignored
        applyStimulus(16'd6, 16'd7, 1'b0);
        pronto_at = -1;
        held      = 32'hDEAD_BEEF;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (pronto) begin
                pronto_at = k;
                held      = {saidaHi, saidaLo};
            end
            iniciar  = (k == 4 || k == 16);
            entradaA = 16'h0100 + 16'(k);
            entradaB = 16'h0200 + 16'(k);
        end
        checkOutput("repulse_latency", 32'(pronto_at), 32'd17);
        checkOutput("repulse_product", held, 32'd42);
        checkOutput("repulse_no_restart", {31'd0, ocupado}, 32'd0);

        // Asynchronous reset in the middle of CALCULA
        applyStimulus(16'h1234, 16'h5678, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            @(negedge clock);
        end
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_outputs", {saidaHi, saidaLo}, 32'h0000_0000);
        checkOutput("midreset_flags", {30'd0, pronto, ocupado}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        pronto_hits = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (pronto || ocupado) pronto_hits++;
        end
        checkOutput("midreset_discarded", 32'(pronto_hits), 32'd0);
        runOp("after_reset_2x2", 16'd2, 16'd2, 1'b0, 32'h0000_0004);

        // Back-to-back: iniciar held high restarts on the edge after FIM
        @(negedge clock);
        entradaA = 16'd3;
        entradaB = 16'd5;
        comSinal = 1'b0;
        iniciar  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        entradaA = 16'd9;
        entradaB = 16'd9;
        pronto_at = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (pronto) begin
                pronto_at = k;
                break;
            end
        end
        checkOutput("b2b_first_latency", 32'(pronto_at), 32'd17);
        checkOutput("b2b_first_product", {saidaHi, saidaLo}, 32'h0000_000F);
        @(posedge clock);
        @(negedge clock);
        iniciar = 1'b0;
        checkOutput("b2b_restarted", {31'd0, ocupado}, 32'd1);
        pronto_at = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (pronto) begin
                pronto_at = k;
                break;
            end
        end
        checkOutput("b2b_second_latency", 32'(pronto_at), 32'd17);
        checkOutput("b2b_second_product", {saidaHi, saidaLo}, 32'd81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_seq16.md
Name: mult_seq16

Overview:
- Sequential 16x16 shift-add multiplier. Feeds the ALU-output select mux: saidaHi and saidaLo drive two of its 16-bit data inputs, so MULT results reach the writeback path.
- Started by the control unit with a one-cycle iniciar pulse. Returns a 32-bit product after a fixed latency, flagged by a one-cycle pronto pulse.
- Supports unsigned and two's-complement operands, selected per operation.

Parameters:
LARGURA, 16, operand width; product is 2*LARGURA
LARG_CONT, 5, iteration counter width; must satisfy 2**LARG_CONT > LARGURA

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
iniciar  input  1  start request; sampled only in state OCIOSO
comSinal  input  1  1 = signed (two's complement) operands, 0 = unsigned; sampled with iniciar
entradaA  input  16  multiplicand; sampled with iniciar
entradaB  input  16  multiplier; sampled with iniciar
saidaHi  output  16  product bits [31:16]
saidaLo  output  16  product bits [15:0]
pronto  output  1  one-cycle pulse: new product valid
ocupado  output  1  high while an operation is in flight

Behaviour:
- Reset (async, any state, including mid-operation):
  - state = OCIOSO; saidaHi, saidaLo, pronto, ocupado = 0.
  - Internal accumulator, operand registers and counter = 0.
  - Any in-flight operation is discarded.
- States: OCIOSO, CALCULA, FIM.
- OCIOSO:
  - ocupado = 0.
  - On an edge with iniciar = 1, latch operands:
    - Unsigned, or signed with non-negative inputs: latch values as-is.
    - Signed and negative: latch the magnitude (0x8000 becomes 32768, unsigned).
    - Record sinalNeg = comSinal & (A[15] ^ B[15]).
  - Clear the 32-bit accumulator; contador = 0; go to CALCULA.
- CALCULA:
  - ocupado = 1.
  - Each edge:
    - If the multiplier LSB is 1, add the multiplicand to accumulator[31:16] with a 17-bit sum (carry kept).
    - Shift the {carry, accumulator, multiplier} combination right by 1.
    - contador += 1.
  - After exactly 16 iterations (contador reaches 15 at its last add), go to FIM.
- FIM:
  - On entry edge: write saidaHi/saidaLo = sinalNeg ? two's-complement negate of the 32-bit magnitude product : the magnitude product.
  - pronto = 1 for exactly this one cycle; ocupado = 1.
  - Next edge returns unconditionally to OCIOSO.
- Latency: iniciar sampled at edge 0 → CALCULA for edges 1..16 → outputs written and pronto asserted after edge 17. Fixed; independent of operand values.
- saidaHi and saidaLo hold their value until the next FIM or reset. They never show partial products.
- iniciar while in CALCULA or FIM: ignored, no queuing. Operand changes during an operation do not affect the result.
- Back-to-back: iniciar held high or re-pulsed in OCIOSO on the edge after FIM starts the next operation. Minimum issue interval is 18 cycles.
- Arithmetic:
  - Unsigned range is full 0..0xFFFE_0001.
  - Signed 0x8000*0x8000 = 0x4000_0000, with no overflow.
  - Zero product with sinalNeg = 1 yields 0.
- Outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - State encoding constants OCIOSO=2'b00, CALCULA=2'b01, FIM=2'b10.
  - LARGURA and the iteration count constant, so the control unit uses the same latency figure.
- No sub-module required. The 32-bit negate and magnitude conversion stay inline.
- The datapath is one always block; the FSM is a second always block.

Test Plan:
- Unsigned 3 x 5, comSinal=0 → pronto exactly 17 cycles after the iniciar edge; saidaHi=0x0000, saidaLo=0x000F; ocupado high for 17 cycles.
- Unsigned 0xFFFF x 0xFFFF → saidaHi=0xFFFE, saidaLo=0x0001.
- Signed sign cases:
  - 0xFFFF (-1) x 0x0007 → 0xFFFF_FFF9.
  - 0x8000 x 0x8000 → 0x4000_0000.
  - 0x8000 x 0x0001 → 0xFFFF_8000.
- iniciar re-pulsed with new operands at cycles 5 and 17 of an operation → ignored; first result unchanged; next accepted start only from OCIOSO.
- Reset asserted asynchronously at cycle 9 of CALCULA → outputs immediately 0, state OCIOSO, no pronto; a fresh 2 x 2 after release gives 0x0000_0004.
- Previous result held: after 3 x 5 completes, idle 20 cycles with changing operands → saidaLo stays 0x000F; pronto stays 0.
